rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Parametrised, pipelined RV32I decode stage with a small instruction queue in front. It accepts fetched instructions and their PCs over a valid/ready handshake, buffers them in a FIFO of configurable depth, and decodes the head entry into a registered bundle: register indices, func3/funcQual, write-back enable, opcode class, all five immediate formats, and an illegal flag. It sits between fetch and register-read/execute and supports a single-cycle pipeline flush.

## Interface
- PC_W, 32, width of carried PC
- FIFO_DEPTH, 2, instruction queue entries; power of two, >= 2
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard all queued and output-held instructions
- inValid  in  1  instr/inPc valid
- inReady  out  1  queue can accept; = (count < FIFO_DEPTH)
- instr  in  32  instruction word
- inPc  in  PC_W  instruction address
- outValid  out  1  decoded bundle valid
- outReady  in  1  consumer accepts bundle
- outPc  out  PC_W  PC of decoded instruction
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20]
- func3  out  3  instr[14:12]
- funcQual  out  1  operation qualifier
- writeBackEn  out  1  instruction writes rd
- opClass  out  4  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE, 15 illegal
- imm  out  32  format-selected immediate
- isShift  out  1  ALU_R/ALU_I with func3 001 or 101
- illegal  out  1  undecodable instruction
- isMulDiv  out  1  RV32M op (tied 0 without macro)

## Operation
- Push: inValid && inReady && !flush writes {instr, inPc} at wrPtr. Pop: head valid && (!outValid || outReady) && !flush loads the output register from the combinational decode of the head.
- Output register holds the bundle stable while outValid && !outReady.
- Opcode instr[6:2]: 01100 ALU_R, 00100 ALU_I, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 11001 JALR, 01101 LUI, 00101 AUIPC, 11100 SYSTEM, 00011 FENCE; anything else is illegal.
- Immediates: I = sext(instr[31:20]) for ALU_I/LOAD/JALR/SYSTEM; S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); J = sext({[31],[19:12],[20],[30:21],0}); U = {[31:12],12'b0} for LUI/AUIPC; 0 otherwise.
- funcQual = instr[30] for ALU_R and for shift ALU_I; 0 otherwise.
- illegal when: instr[1:0] != 11; unknown opcode; ALU_R funct7 not 0000000, or 0100000 with func3 other than 000/101; shift ALU_I funct7 not 0000000, or 0100000 with func3 other than 101.
- writeBackEn = 1 for ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC; forced 0 when rd == 0 or illegal.
- When illegal: opClass = 15 and writeBackEn = 0; the bundle is still delivered in order.

## Timing
- Reset: count, pointers, outValid, and every output-register field are 0 (opClass 0, imm 0, outPc 0). inReady = 1.
- Latency: push at edge N; the bundle is registered at edge N+1; outValid is high after N+1. Throughput is 1 per cycle when outReady is held high.
- Full FIFO: inReady = 0 with no same-cycle pass-through; a pop in that cycle re-opens inReady the next cycle.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo FIFO_DEPTH.
- Flush: at the next edge count = 0, pointers = 0 and outValid = 0; any same-cycle push or pop is dropped; the other output fields keep their values.
- resetn asserted mid-stream clears all state immediately, independent of clk.

## Configuration
- RV32M_DECODE_EN defined: ALU_R with funct7 = 0000001 (any func3) is legal; isMulDiv = 1, funcQual = 0, writeBackEn follows rd rule.
- Undefined: that encoding is illegal; isMulDiv is constant 0.

## Test plan
- ADD x3,x1,x2 (0x002081B3) pushed at edge N, outReady = 1 -> at N+1: outValid = 1, rd = 3, rs1 = 1, rs2 = 2, func3 = 0, funcQual = 0, writeBackEn = 1, opClass = 0.
- SRAI x5,x6,3 (0x40335293) -> opClass = 1, isShift = 1, funcQual = 1, imm = 0x00000403, writeBackEn = 1.
- BEQ x0,x0,-4 (0xFE000EE3) -> opClass = 4, imm = 0xFFFFFFFC, writeBackEn = 0; 0x00000000 -> illegal = 1, opClass = 15.
- FIFO_DEPTH = 2, outReady = 0, push 3 instructions -> first held on output, inReady = 0 after the third push; raise outReady -> bundles emerge in push order with PCs intact.
- With 2 queued and 1 held, pulse flush -> outValid = 0 and inReady = 1 next cycle; the next push emerges 1 cycle later with no stale entries.
- MUL x2,x1,x2 (0x02208133) -> with RV32M_DECODE_EN: illegal = 0, isMulDiv = 1, writeBackEn = 1; without it: illegal = 1, writeBackEn = 0.

Source files
------------

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I decode stage with a small instruction FIFO in front.
// Fetched {instr, pc} pairs are queued, the head entry is decoded
// combinationally, and the result is captured into a registered output bundle
// behind a valid/ready handshake. A one-cycle flush empties the queue and
// invalidates the held bundle.
// Optional feature: define RV32M_DECODE_EN to accept RV32M (funct7 = 0000001)
// register-register encodings as legal and to drive isMulDiv.
module rv_decode_stage #(
  parameter int PC_W       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] inPc,
  output logic            outValid,
  input  logic            outReady,
  output logic [PC_W-1:0] outPc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3,
  output logic            funcQual,
  output logic            writeBackEn,
  output logic [3:0]      opClass,
  output logic [31:0]     imm,
  output logic            isShift,
  output logic            illegal,
  output logic            isMulDiv
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    OP_ALU_R   = 4'd0,
    OP_ALU_I   = 4'd1,
    OP_LOAD    = 4'd2,
    OP_STORE   = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_JAL     = 4'd5,
    OP_JALR    = 4'd6,
    OP_LUI     = 4'd7,
    OP_AUIPC   = 4'd8,
    OP_SYSTEM  = 4'd9,
    OP_FENCE   = 4'd10,
    OP_ILLEGAL = 4'd15
  } opClass_e;

  // FIFO storage and bookkeeping
  logic [31:0]     instrMem_q [FIFO_DEPTH];
  logic [PC_W-1:0] pcMem_q    [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output bundle registers
  logic            outValid_q, outValid_d;
  logic [PC_W-1:0] outPc_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      func3_q;
  logic            funcQual_q;
  logic            writeBackEn_q;
  opClass_e        opClass_q;
  logic [31:0]     imm_q;
  logic            isShift_q;
  logic            illegal_q;

  // Handshake qualifiers
  logic push, pop, headValid;

  // Head entry and its decode
  logic [31:0]     headInstr;
  logic [PC_W-1:0] headPc;
  logic [4:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      decRd;
  opClass_e        baseClass;
  opClass_e        decClass;
  logic [31:0]     decImm;
  logic            decQual;
  logic            decShift;
  logic            decIllegal;
  logic            decWbClass;
  logic            decWb;
`ifdef RV32M_DECODE_EN
  logic            decMulDiv;
  logic            isMulDiv_q;
`endif

  assign inReady   = (count_q < CNT_W'(FIFO_DEPTH));
  assign headValid = (count_q != '0);
  assign push      = inValid && inReady && !flush;
  assign pop       = headValid && (!outValid_q || outReady) && !flush;

  assign headInstr = instrMem_q[rdPtr_q];
  assign headPc    = pcMem_q[rdPtr_q];
  assign opcode    = headInstr[6:2];
  assign f3        = headInstr[14:12];
  assign f7        = headInstr[31:25];
  assign decRd     = headInstr[11:7];

  // Queue storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= instr;
      pcMem_q[wrPtr_q]    <= inPc;
    end
  end

  // Next-state for pointers and occupancy; flush empties the queue outright
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Opcode classification, immediate selection and legality of the head entry
  always_comb begin
    baseClass  = OP_ILLEGAL;
    decImm     = '0;
    decQual    = 1'b0;
    decShift   = 1'b0;
    decIllegal = 1'b0;
    decWbClass = 1'b0;
`ifdef RV32M_DECODE_EN
    decMulDiv  = 1'b0;
`endif
    case (opcode)
      5'b01100: begin
        baseClass  = OP_ALU_R;
        decWbClass = 1'b1;
        decShift   = (f3 == 3'b001) || (f3 == 3'b101);
        decQual    = headInstr[30];
        if (f7 == 7'b0000000) begin
          decIllegal = 1'b0;
        end else if (f7 == 7'b0100000) begin
          decIllegal = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef RV32M_DECODE_EN
        end else if (f7 == 7'b0000001) begin
          decMulDiv = 1'b1;
          decQual   = 1'b0;
`endif
        end else begin
          decIllegal = 1'b1;
        end
      end
      5'b00100: begin
        baseClass  = OP_ALU_I;
        decWbClass = 1'b1;
        decImm     = {{20{headInstr[31]}}, headInstr[31:20]};
        decShift   = (f3 == 3'b001) || (f3 == 3'b101);
        if (decShift) begin
          decQual = headInstr[30];
          if (f7 == 7'b0000000) begin
            decIllegal = 1'b0;
          end else if ((f7 == 7'b0100000) && (f3 == 3'b101)) begin
            decIllegal = 1'b0;
          end else begin
            decIllegal = 1'b1;
          end
        end
      end
      5'b00000: begin
        baseClass  = OP_LOAD;
        decWbClass = 1'b1;
        decImm     = {{20{headInstr[31]}}, headInstr[31:20]};
      end
      5'b01000: begin
        baseClass = OP_STORE;
        decImm    = {{20{headInstr[31]}}, headInstr[31:25], headInstr[11:7]};
      end
      5'b11000: begin
        baseClass = OP_BRANCH;
        decImm    = {{19{headInstr[31]}}, headInstr[31], headInstr[7],
                     headInstr[30:25], headInstr[11:8], 1'b0};
      end
      5'b11011: begin
        baseClass  = OP_JAL;
        decWbClass = 1'b1;
        decImm     = {{11{headInstr[31]}}, headInstr[31], headInstr[19:12],
                      headInstr[20], headInstr[30:21], 1'b0};
      end
      5'b11001: begin
        baseClass  = OP_JALR;
        decWbClass = 1'b1;
        decImm     = {{20{headInstr[31]}}, headInstr[31:20]};
      end
      5'b01101: begin
        baseClass  = OP_LUI;
        decWbClass = 1'b1;
        decImm     = {headInstr[31:12], 12'b0};
      end
      5'b00101: begin
        baseClass  = OP_AUIPC;
        decWbClass = 1'b1;
        decImm     = {headInstr[31:12], 12'b0};
      end
      5'b11100: begin
        baseClass = OP_SYSTEM;
        decImm    = {{20{headInstr[31]}}, headInstr[31:20]};
      end
      5'b00011: begin
        baseClass = OP_FENCE;
      end
      default: begin
        baseClass  = OP_ILLEGAL;
        decIllegal = 1'b1;
      end
    endcase
    if (headInstr[1:0] != 2'b11) decIllegal = 1'b1;
`ifdef RV32M_DECODE_EN
    if (decIllegal) decMulDiv = 1'b0;
`endif
  end

  assign decClass = decIllegal ? OP_ILLEGAL : baseClass;
  assign decWb    = decWbClass && (decRd != 5'd0) && !decIllegal;

  // Output valid: set on pop, cleared once consumed or on flush
  always_comb begin
    outValid_d = outValid_q;
    if (flush) begin
      outValid_d = 1'b0;
    end else if (pop) begin
      outValid_d = 1'b1;
    end else if (outReady) begin
      outValid_d = 1'b0;
    end
  end

  // Output bundle register; fields only change when a new entry is popped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outValid_q    <= 1'b0;
      outPc_q       <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      func3_q       <= '0;
      funcQual_q    <= 1'b0;
      writeBackEn_q <= 1'b0;
      opClass_q     <= OP_ALU_R;
      imm_q         <= '0;
      isShift_q     <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef RV32M_DECODE_EN
      isMulDiv_q    <= 1'b0;
`endif
    end else begin
      outValid_q <= outValid_d;
      if (pop) begin
        outPc_q       <= headPc;
        rd_q          <= decRd;
        rs1_q         <= headInstr[19:15];
        rs2_q         <= headInstr[24:20];
        func3_q       <= f3;
        funcQual_q    <= decQual;
        writeBackEn_q <= decWb;
        opClass_q     <= decClass;
        imm_q         <= decImm;
        isShift_q     <= decShift;
        illegal_q     <= decIllegal;
`ifdef RV32M_DECODE_EN
        isMulDiv_q    <= decMulDiv;
`endif
      end
    end
  end

  assign outValid    = outValid_q;
  assign outPc       = outPc_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign func3       = func3_q;
  assign funcQual    = funcQual_q;
  assign writeBackEn = writeBackEn_q;
  assign opClass     = opClass_q;
  assign imm         = imm_q;
  assign isShift     = isShift_q;
  assign illegal     = illegal_q;
`ifdef RV32M_DECODE_EN
  assign isMulDiv    = isMulDiv_q;
`else
  assign isMulDiv    = 1'b0;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: scoreboard bench for rv_decode_stage. Accepted pushes
// enqueue a hand-computed expected bundle; a monitor pops and compares every
// bundle the DUT hands over on an outValid/outReady handshake.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic [31:0] inPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  func3;
  logic        funcQual;
  logic        writeBackEn;
  logic [3:0]  opClass;
  logic [31:0] imm;
  logic        isShift;
  logic        illegal;
  logic        isMulDiv;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        fq;
    logic        wb;
    logic [3:0]  opc;
    logic [31:0] imm;
    logic        sh;
    logic        ill;
    logic        mul;
  } bundle_t;

  bundle_t expQ[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_SRAI   = 32'h40335293;
  localparam logic [31:0] I_BEQ    = 32'hFE000EE3;
  localparam logic [31:0] I_ZERO   = 32'h00000000;
  localparam logic [31:0] I_MUL    = 32'h02208133;
  localparam logic [31:0] I_SUBBAD = 32'h40001033;
  localparam logic [31:0] I_JAL    = 32'h008000EF;
  localparam logic [31:0] I_SW     = 32'h0020A423;

  rv_decode_stage #(.PC_W(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .inValid(inValid), .inReady(inReady), .instr(instr), .inPc(inPc),
    .outValid(outValid), .outReady(outReady), .outPc(outPc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .funcQual(funcQual),
    .writeBackEn(writeBackEn), .opClass(opClass), .imm(imm),
    .isShift(isShift), .illegal(illegal), .isMulDiv(isMulDiv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic bundle_t mk(input logic [31:0] pc, input logic [4:0] r, input logic [4:0] a,
                                 input logic [4:0] b, input logic [2:0] f, input logic q, input logic w,
                                 input logic [3:0] o, input logic [31:0] im, input logic s,
                                 input logic il, input logic m);
    bundle_t e;
    e = '{pc: pc, rd: r, rs1: a, rs2: b, f3: f, fq: q, wb: w, opc: o, imm: im, sh: s, ill: il, mul: m};
    return e;
  endfunction

  // Hand-computed expected bundles for each directed instruction
  function automatic bundle_t expFor(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t e;
    e = mk(pc, 0, 0, 0, 0, 0, 0, 15, 0, 0, 1, 0);
    case (ins)
      I_ADD:    e = mk(pc, 3, 1, 2, 0, 0, 1, 0, 32'h0, 0, 0, 0);
      I_SRAI:   e = mk(pc, 5, 6, 3, 5, 1, 1, 1, 32'h00000403, 1, 0, 0);
      I_BEQ:    e = mk(pc, 29, 0, 0, 0, 0, 0, 4, 32'hFFFFFFFC, 0, 0, 0);
      I_ZERO:   e = mk(pc, 0, 0, 0, 0, 0, 0, 15, 32'h0, 0, 1, 0);
`ifdef RV32M_DECODE_EN
      I_MUL:    e = mk(pc, 2, 1, 2, 0, 0, 1, 0, 32'h0, 0, 0, 1);
`else
      I_MUL:    e = mk(pc, 2, 1, 2, 0, 0, 0, 15, 32'h0, 0, 1, 0);
`endif
      I_SUBBAD: e = mk(pc, 0, 0, 0, 1, 1, 0, 15, 32'h0, 1, 1, 0);
      I_JAL:    e = mk(pc, 1, 0, 8, 0, 0, 1, 5, 32'h00000008, 0, 0, 0);
      I_SW:     e = mk(pc, 8, 1, 2, 2, 0, 0, 3, 32'h00000008, 0, 0, 0);
      default:  e = mk(pc, 0, 0, 0, 0, 0, 0, 15, 0, 0, 1, 0);
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one instruction until accepted (bounded), recording its expectation
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc);
    bit accepted;
    accepted = 1'b0;
    inValid  = 1'b1;
    instr    = ins;
    inPc     = pc;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (inReady) begin
        @(posedge clk);
        accepted = 1'b1;
        expQ.push_back(expFor(ins, pc));
      end
    end
    #1;
    inValid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout got=not_accepted expected=accepted pc=%0h", pc);
    end
  endtask

  // Wait (bounded) for all expected bundles to be consumed
  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) break;
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_queue_empty"}, 128'(expQ.size()), 128'd0);
    checkOutput({name, "_outValid_idle"}, 128'(outValid), 128'd0);
  endtask

  // Scoreboard monitor: compare on every output handshake
  always @(negedge clk) begin
    bundle_t act;
    bundle_t e;
    if (resetn && !flush && outValid && outReady) begin
      act = '{pc: outPc, rd: rd, rs1: rs1, rs2: rs2, f3: func3, fq: funcQual, wb: writeBackEn,
              opc: opClass, imm: imm, sh: isShift, ill: illegal, mul: isMulDiv};
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_bundle got=%0h expected=none", act);
      end else begin
        e = expQ.pop_front();
        checkOutput("bundle", 128'(act), 128'(e));
      end
    end
  end

  initial begin
    int c0;
    resetn   = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    instr    = '0;
    inPc     = '0;
    #12 resetn = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_outValid", 128'(outValid), 128'd0);
    checkOutput("rst_inReady", 128'(inReady), 128'd1);
    checkOutput("rst_opClass", 128'(opClass), 128'd0);
    checkOutput("rst_imm", 128'(imm), 128'd0);
    checkOutput("rst_outPc", 128'(outPc), 128'd0);
    checkOutput("rst_rd", 128'(rd), 128'd0);
    checkOutput("rst_wb", 128'(writeBackEn), 128'd0);
    @(posedge clk);
    #1;

    // Streaming decode with consumer always ready
    outReady = 1'b1;
    c0 = cyc;
    applyStimulus(I_ADD, 32'h100);
    checkOutput("latency_before", 128'(outValid), 128'd0);
    applyStimulus(I_SRAI, 32'h104);
    checkOutput("latency_after", 128'(outValid), 128'd1);
    applyStimulus(I_BEQ, 32'h108);
    applyStimulus(I_ZERO, 32'h10C);
    applyStimulus(I_MUL, 32'h110);
    applyStimulus(I_SUBBAD, 32'h114);
    applyStimulus(I_JAL, 32'h118);
    applyStimulus(I_SW, 32'h11C);
    checkOutput("throughput_cycles", 128'(cyc - c0), 128'd8);
    drain("stream");

    // Backpressure until the queue is full, then release
    outReady = 1'b0;
    applyStimulus(I_ADD, 32'h200);
    applyStimulus(I_SRAI, 32'h204);
    applyStimulus(I_BEQ, 32'h208);
    checkOutput("full_inReady", 128'(inReady), 128'd0);
    checkOutput("full_outValid", 128'(outValid), 128'd1);
    checkOutput("full_heldPc", 128'(outPc), 128'h200);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reopen_inReady", 128'(inReady), 128'd1);
    drain("full");

    // Flush with two queued and one held
    outReady = 1'b0;
    applyStimulus(I_JAL, 32'h300);
    applyStimulus(I_SW, 32'h304);
    applyStimulus(I_ADD, 32'h308);
    flush = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_outValid", 128'(outValid), 128'd0);
    checkOutput("flush_inReady", 128'(inReady), 128'd1);
    checkOutput("flush_keepPc", 128'(outPc), 128'h300);
    outReady = 1'b1;
    applyStimulus(I_SW, 32'h400);
    checkOutput("postflush_before", 128'(outValid), 128'd0);
    @(posedge clk);
    #1;
    checkOutput("postflush_after", 128'(outValid), 128'd1);
    drain("flush");

    // Asynchronous reset mid-stream
    outReady = 1'b0;
    applyStimulus(I_SRAI, 32'h500);
    applyStimulus(I_BEQ, 32'h504);
    #3 resetn = 1'b0;
    #1;
    checkOutput("async_rst_outValid", 128'(outValid), 128'd0);
    checkOutput("async_rst_inReady", 128'(inReady), 128'd1);
    checkOutput("async_rst_outPc", 128'(outPc), 128'd0);
    expQ.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b1;
    applyStimulus(I_JAL, 32'h600);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
